// File: rtl/match_report_if.sv
// rtl/match_report_if.sv - match input and byte-wide UART start/complete handshake bundle
interface match_report_if;
  logic       match_valid;
  logic [9:0] match_x;
  logic [8:0] match_y;
  logic       frame_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_complete;

  modport master (
    output match_valid, match_x, match_y, frame_done, tx_complete,
    input  tx_start, tx_data
  );

  modport slave (
    input  match_valid, match_x, match_y, frame_done, tx_complete,
    output tx_start, tx_data
  );
endinterface

// File: rtl/match_report_sequencer.sv
// rtl/match_report_sequencer.sv - queues match coordinates and sends them as framed UART byte packets
// Optional 6th checksum byte per packet when MATCH_REPORT_CHECKSUM_EN is defined.
module match_report_sequencer #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         DROP_W     = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  match_report_if.slave     mr_if,
  output logic              fifo_full_o,
  output logic [DROP_W-1:0] dropped_o,
  output logic              idle_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef MATCH_REPORT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_NEXT = 2'd3;

  logic [18:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DROP_W-1:0] dropped_q;

  logic [1:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [18:0] pkt_q, pkt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        term_act_q, term_act_d;
  logic        term_pend_q, term_pend_d;

  logic fifo_empty, fifo_full, push, pop, drop, last_done;

  // Packet register holds {x[9:0], y[8:0]}; bytes are sliced from it on demand.
  function automatic logic [7:0] pkt_byte(input logic [18:0] p, input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = HEADER;
      3'd1:    b = {6'b0, p[18:17]};
      3'd2:    b = p[16:9];
      3'd3:    b = {7'b0, p[8]};
      3'd4:    b = p[7:0];
`ifdef MATCH_REPORT_CHECKSUM_EN
      3'd5:    b = {6'b0, p[18:17]} ^ p[16:9] ^ {7'b0, p[8]} ^ p[7:0];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push against a full FIFO still lands.
  assign push       = mr_if.match_valid && (!fifo_full || pop);
  assign drop       = mr_if.match_valid && fifo_full && !pop;
  assign last_done  = (state_q == S_NEXT) && (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pkt_d       = pkt_q;
    tx_data_d   = tx_data_q;
    term_act_d  = term_act_q;
    term_pend_d = term_pend_q;

    if (mr_if.frame_done) begin
      term_pend_d = 1'b1;
    end else if (last_done && term_act_q) begin
      term_pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pkt_d      = mem[rd_ptr_q];
          term_act_d = 1'b0;
          idx_d      = 3'd0;
          tx_data_d  = HEADER;
          state_d    = S_SEND;
        end else if (term_pend_q) begin
          pkt_d      = '1;
          term_act_d = 1'b1;
          idx_d      = 3'd0;
          tx_data_d  = HEADER;
          state_d    = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (mr_if.tx_complete) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          idx_d     = 3'd0;
          tx_data_d = 8'h00;
          state_d   = S_IDLE;
        end else begin
          idx_d     = idx_q + 3'd1;
          tx_data_d = pkt_byte(pkt_q, idx_q + 3'd1);
          state_d   = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr_q] <= {mr_if.match_x, mr_if.match_y};
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dropped_q   <= '0;
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      pkt_q       <= '0;
      tx_data_q   <= 8'h00;
      term_act_q  <= 1'b0;
      term_pend_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop && (dropped_q != '1)) dropped_q <= dropped_q + DROP_W'(1);
      state_q     <= state_d;
      idx_q       <= idx_d;
      pkt_q       <= pkt_d;
      tx_data_q   <= tx_data_d;
      term_act_q  <= term_act_d;
      term_pend_q <= term_pend_d;
    end
  end

  assign mr_if.tx_start = (state_q == S_SEND);
  assign mr_if.tx_data  = tx_data_q;
  assign fifo_full_o    = fifo_full;
  assign dropped_o      = dropped_q;
  assign idle_o         = (state_q == S_IDLE) && fifo_empty && !term_pend_q;

endmodule

// File: doc/match_report_sequencer.md
Name: match_report_sequencer

Overview:
- Sits between the vertical SAD processor match output and the UART transmitter.
- Queues match coordinates (x, y) in a small FIFO and serialises each one into a framed byte packet.
- Drives the UART one byte at a time using a start/complete handshake.
- On end-of-image, drains the queue and then sends a terminator packet carrying the all-ones "no match" coordinate.

Parameters:
- FIFO_DEPTH, 8, match entries buffered; power of two, minimum 2.
- HEADER, 8'hA5, first byte of every packet.
- DROP_W, 8, width of the saturating dropped-match counter.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- match_valid  in  1  one-cycle pulse: match_x/match_y hold a match.
- match_x  in  10  match column, 0..639.
- match_y  in  9  match row, 0..479.
- frame_done  in  1  one-cycle pulse: image scan finished.
- tx_start  out  1  one-cycle pulse: UART must latch tx_data.
- tx_data  out  8  byte to send; held stable from tx_start until tx_complete.
- tx_complete  in  1  one-cycle pulse: UART finished the current byte.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- dropped  out  DROP_W  count of matches lost to overflow; saturates at all ones.
- idle  out  1  FSM in IDLE, FIFO empty, no terminator pending.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; FIFO pointers and count go to 0; terminator-pending flag goes to 0.
  - Outputs: tx_start=0, tx_data=8'h00, fifo_full=0, dropped=0, idle=1.
  - Reset asserted mid-packet aborts the packet immediately; no partial bytes resume after release.
- FIFO:
  - Push on match_valid when not full; the entry is {match_x, match_y}.
  - Push when full with no pop in the same cycle: the entry is discarded and dropped increments, saturating.
  - Push and pop in the same cycle while full: both happen, nothing is dropped, and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Packet format, 5 bytes sent in order:
  - byte 0: HEADER
  - byte 1: {6'b0, x[9:8]}
  - byte 2: x[7:0]
  - byte 3: {7'b0, y[8]}
  - byte 4: y[7:0]
- Terminator packet:
  - Same format with x=10'h3FF and y=9'h1FF.
  - Bytes: A5 03 FF 01 FF.
- frame_done sets the terminator-pending flag.
  - A repeat pulse while the flag is already set has no further effect (exactly one terminator is sent).
  - The flag clears when the terminator's last byte completes.
- FSM states and transitions:
  - IDLE:
    - If the FIFO is not empty: pop the head into the packet register and go to SEND.
    - Else if the terminator is pending: load the terminator and go to SEND.
    - Matches therefore always precede the terminator, including matches pushed after frame_done.
  - SEND: drive tx_start=1 for exactly one cycle with tx_data = byte[idx], then go to WAIT.
  - WAIT: hold tx_data; on tx_complete, go to NEXT. A tx_complete seen in any other state is ignored.
  - NEXT:
    - If idx is the last byte: set idx=0 and go to IDLE.
    - Otherwise increment idx and go to SEND.
- Latency:
  - match_valid with an empty FIFO in IDLE gives tx_start 2 cycles later (push cycle, then IDLE pop cycle, then SEND).
  - tx_complete gives the next tx_start 2 cycles later (WAIT→NEXT→SEND).
- Throughput is limited only by the UART.
- The FIFO keeps accepting matches during transmission.

Optional Feature:
- Macro: MATCH_REPORT_CHECKSUM_EN.
- Defined:
  - Each packet, including the terminator, carries a 6th byte equal to the XOR of bytes 1..4.
  - The terminator checksum is 03^FF^01^FF = 8'h02.
  - The last-byte index is 5.
- Undefined: packets are 5 bytes and the last-byte index is 4.

Test Plan:
- Single match (x=10'd517, y=9'd300) with tx_complete returned 3 cycles after each tx_start -> bytes A5 02 05 01 2C; idle returns to 1 after the 5th tx_complete; dropped=0.
- 10 back-to-back match_valid pulses with FIFO_DEPTH=8 while the UART is stalled -> the first match is popped immediately, so 9 matches are accepted in total, then fifo_full=1 and dropped=1; releasing the UART transmits 9 packets in push order.
- frame_done asserted with 2 matches queued, plus a 3rd match pushed after frame_done -> 3 match packets, then A5 03 FF 01 FF; a second frame_done pulse mid-drain produces no extra terminator.
- reset pulled low during byte 2 of a packet -> tx_start=0 and tx_data=00 immediately; FIFO empty; after release, a new match transmits a complete packet starting at A5.
- Push and pop in the same cycle while full -> count stays FIFO_DEPTH and dropped is unchanged; tx_complete pulses injected in IDLE or SEND are ignored, with no byte skipped.
- With MATCH_REPORT_CHECKSUM_EN defined, match x=1, y=2 -> bytes A5 00 01 00 02 03.
